// File: rtl/serial_x_if.sv
// Handshake/data bundle between a frame controller and serial_x_driver.
// The controller drives start/data/len/msb_first; the driver returns the serial bit and status.
interface serial_x_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;
  logic             msb_first;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, data, len, msb_first,
    input  x, valid, busy, done
  );

  modport slave (
    input  start, data, len, msb_first,
    output x, valid, busy, done
  );
endinterface

// File: rtl/serial_x_driver.sv
// Serialises a parallel word onto x, one bit per clock, MSB- or LSB-first,
// with a busy/done handshake that allows zero-gap restart from the DONE cycle.
module serial_x_driver #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  serial_x_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             msb_q, msb_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] load_word;

  // MSB-first frames are left-aligned so the frame's top bit always leaves from shreg[WIDTH-1].
  always_comb begin
    eff_len = bus.len;
    if (bus.len == '0 || bus.len > WIDTH_L) eff_len = WIDTH_L;
    load_word = bus.msb_first ? (bus.data << (WIDTH_L - eff_len)) : bus.data;
  end

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SHIFT;
          msb_d   = bus.msb_first;
          cnt_d   = eff_len - LEN_W'(1);
          x_d     = bus.msb_first ? load_word[WIDTH-1] : load_word[0];
          shreg_d = bus.msb_first ? (load_word << 1) : (load_word >> 1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // cnt_q holds the number of bits still to send after the one now on x.
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - LEN_W'(1);
          x_d     = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
          shreg_d = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/serial_x_driver.md
Name: serial_x_driver

Overview:
Transmit end of the single-bit serial stream `x` consumed by the sequence-detector FSM blocks. Loads a parallel word and shifts it out one bit per clock, MSB- or LSB-first, with a selectable bit count. Provides a busy/done handshake so a controller can chain frames back-to-back. Replaces hand-written `x` stimulus with a synthesizable driver in the same clock domain as the FSM.

Parameters:
WIDTH, 8, width of the parallel data word.
LEN_W, 4, width of the `len` field; must satisfy 2**LEN_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to send a frame; sampled on rising edge of `clk`.
data  input  WIDTH  word to send; captured when `start` is accepted.
len  input  LEN_W  bit count; captured with `data`. Value 0 means WIDTH. Values above WIDTH clamp to WIDTH.
msb_first  input  1  captured with `data`. 1 sends `data[L-1]` down to `data[0]`. 0 sends `data[0]` up to `data[L-1]`.
x  output  1  serial bit; registered.
valid  output  1  high while `x` carries a frame bit; registered.
busy  output  1  high while a frame is in flight; registered.
done  output  1  one-cycle pulse after the last bit; registered.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE, `x`=0, `valid`=0, `busy`=0, `done`=0, shift register=0, bit counter=0.
- The effective length L is `len` (0 maps to WIDTH; values above WIDTH map to WIDTH). Only the low L bits of `data` are sent.
- States: IDLE, SHIFT, DONE. Encoded in 2 bits; the unused code returns to IDLE.
- IDLE:
  - `busy`=0, `valid`=0, `x`=0.
  - `start`=1 captures `data`, L and `msb_first`, then moves to SHIFT.
  - The first bit appears on `x`, with `valid`=1 and `busy`=1, in the cycle immediately after the accepting edge (latency 1).
- SHIFT:
  - One bit per clock; `valid`=1 and `busy`=1 throughout.
  - The counter counts the L bits. After the edge that retires bit L, the block enters DONE.
  - `start` is ignored in SHIFT; inputs are not re-captured.
- DONE:
  - Lasts exactly one cycle: `done`=1, `valid`=0, `x`=0, `busy`=0.
  - `start`=1 in this cycle is accepted. The next cycle carries bit 0 of the new frame, giving a zero-gap restart with only the single DONE cycle between frames.
  - Otherwise the block moves to IDLE.
- Frame timing: with `start` accepted at edge k, bit i is on `x` during the cycle after edge k+i, for i=0..L-1. `done`=1 in the cycle after edge k+L.
- `done` and `valid` are never high in the same cycle.
- `busy` is high exactly while `valid` is high.
- Reset asserted mid-frame: outputs clear immediately (asynchronously) and the frame is abandoned. After reset releases, the block sits in IDLE and needs a fresh `start`.
- `data`, `len` and `msb_first` are don't-care except on the accepting edge.

Test Plan:
- Reset held 30 ns, then WIDTH=8, `data`=8'b1011_0010, `len`=0, `msb_first`=1, `start` pulsed one cycle -> `x` = 1,0,1,1,0,0,1,0 over 8 cycles with `valid`=1; `done`=1 on the 9th cycle; IDLE on the 10th.
- `data`=8'h06, `len`=3, `msb_first`=0 -> `x` = 0,1,1 with `valid`=1 for 3 cycles, then `done` pulse; bits above index 2 never appear.
- `len`=12, `data`=8'hA5, `msb_first`=1 -> clamped to 8 bits: `x` = 1,0,1,0,0,1,0,1; `done` after the 8th bit.
- `start` held high for the whole frame with `data` changed every cycle -> the first captured word is sent unchanged. The second frame begins in the cycle after the `done` cycle, using `data` sampled on the DONE-cycle edge.
- Back-to-back: `start` pulsed in the DONE cycle with `data`=8'hFF, `len`=2 -> `x` = 1,1 follows after exactly one `valid`=0 cycle.
- `reset` asserted asynchronously mid-frame, after 3 bits of 8'hF0 MSB-first -> `x`, `valid`, `busy`, `done` go to 0 before the next clock edge. No further bits after release until a new `start`, which sends a full fresh frame.
